// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing the write port of fifo_syn
// among NUM_REQ valid/ready producers. A grant lasts until the producer's
// last beat or MAX_BURST beats. The FIFO's full flag backpressures the grantee.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          fifo_full,
  output logic                          fifo_cs,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_data_in,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic [15:0]                   wr_count
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, BURST} state_t;

  state_t          state_reg;
  logic [GW-1:0]   grant_reg;
  logic [GW-1:0]   last_grant_reg;
  logic [BW-1:0]   beat_cnt_reg;
  logic [15:0]     wr_count_reg;

  logic [DATA_WIDTH-1:0] data_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] grant_data;
  logic                  burst_active;
  logic                  xfer;
  logic                  burst_end;
  logic                  pick_found;
  logic [GW-1:0]         pick_idx;

  // Per-producer data slices and ready lines; only the grantee may see ready
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
      assign data_arr[gi]  = req_data[gi*DATA_WIDTH +: DATA_WIDTH];
      assign req_ready[gi] = !rst && burst_active && !fifo_full &&
                             (grant_reg == GW'(gi));
    end
  endgenerate

  assign burst_active = (state_reg == BURST);
  assign grant_data   = data_arr[grant_reg];

  // A beat moves only when the grantee offers one and the FIFO has room
  assign xfer      = burst_active && !rst && req_valid[grant_reg] && !fifo_full;
  // The cap and the producer's last flag both close the burst; together they count once
  assign burst_end = xfer && (req_last[grant_reg] ||
                              (beat_cnt_reg == BW'(MAX_BURST - 1)));

  // Round-robin pick: first requester found searching upward from the previous winner + 1
  always_comb begin
    int            cand;
    logic [GW-1:0] cand_idx;
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = int'(last_grant_reg) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = GW'(cand);
      if (!pick_found && req_valid[cand_idx]) begin
        pick_found = 1'b1;
        pick_idx   = cand_idx;
      end
    end
  end

  // Arbitration FSM with its grant, burst and write counters
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      grant_reg      <= '0;
      last_grant_reg <= GW'(NUM_REQ - 1);
      beat_cnt_reg   <= '0;
      wr_count_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (pick_found) begin
            grant_reg    <= pick_idx;
            beat_cnt_reg <= '0;
            state_reg    <= BURST;
          end
        end
        BURST: begin
          if (xfer) begin
            wr_count_reg <= wr_count_reg + 16'd1;
            beat_cnt_reg <= beat_cnt_reg + BW'(1);
            if (burst_end) begin
              state_reg      <= IDLE;
              last_grant_reg <= grant_reg;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy         = burst_active;
  assign grant_id     = grant_reg;
  assign wr_count     = wr_count_reg;
  assign fifo_wr_en   = xfer;
  assign fifo_cs      = burst_active && !rst;
  assign fifo_data_in = burst_active ? grant_data : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: scoreboard bench. The driver issues per-cycle stimulus
// from producer beat queues, predicts the arbiter's response with a
// transaction-level model and queues expectations; two monitors compare.
module tb_fifo_wr_arbiter;

  localparam int N  = 4;
  localparam int DW = 32;
  localparam int MB = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req_valid;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_last;
  logic [N-1:0]    req_ready;
  logic            fifo_full;
  logic            fifo_cs;
  logic            fifo_wr_en;
  logic [DW-1:0]   fifo_data_in;
  logic [1:0]      grant_id;
  logic            busy;
  logic [15:0]     wr_count;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .fifo_full(fifo_full),
    .fifo_cs(fifo_cs), .fifo_wr_en(fifo_wr_en), .fifo_data_in(fifo_data_in),
    .grant_id(grant_id), .busy(busy), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       busy;
    logic       wr;
    logic [1:0] grant;
    logic [3:0] ready;
    logic [15:0] cnt;
  } cyc_t;

  typedef struct {
    logic [31:0] data;
    int          id;
  } wr_t;

  cyc_t cyc_q[$];
  wr_t  wr_q[$];

  // Producer beat streams
  logic [31:0] pq_data [N][$];
  bit          pq_last [N][$];
  int          seq = 0;

  // Reference model: who holds the port, beats granted so far, last winner
  int          m_grantee;
  int          m_beats;
  int          m_lastw;
  logic [1:0]  m_gid;
  logic [15:0] m_cnt;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic add_beat(input int p, input logic [31:0] d, input bit l);
    pq_data[p].push_back(d);
    pq_last[p].push_back(l);
  endtask

  task automatic add_burst(input int p, input int len);
    for (int k = 0; k < len; k++) begin
      add_beat(p, {8'(p + 1), 24'(seq)}, k == len - 1);
      seq++;
    end
  endtask

  function automatic bit pending();
    bit any;
    any = (m_grantee >= 0);
    for (int i = 0; i < N; i++) if (pq_data[i].size() > 0) any = 1'b1;
    return any;
  endfunction

  task automatic model_reset();
    m_grantee = -1;
    m_beats   = 0;
    m_lastw   = N - 1;
    m_gid     = 2'd0;
    m_cnt     = 16'd0;
  endtask

  // One clock of stimulus plus the model's prediction for the coming edge
  task automatic step(input int vpct, input int fpct, input bit rst_i);
    logic [N-1:0] v;
    bit   full;
    bit   xfer;
    int   g;
    int   w;
    int   sel;
    cyc_t e;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      v[i] = (pq_data[i].size() > 0) && ($urandom_range(99) < vpct);
    full = ($urandom_range(99) < fpct);
    rst       = rst_i;
    fifo_full = full;
    req_valid = v;
    for (int i = 0; i < N; i++) begin
      req_data[i*DW +: DW] = (pq_data[i].size() > 0) ? pq_data[i][0] : 32'd0;
      req_last[i]          = (pq_last[i].size() > 0) ? pq_last[i][0] : 1'b0;
    end
    g    = m_grantee;
    xfer = !rst_i && (g >= 0) && !full && ((g >= 0) ? v[g] : 1'b0);
    e.rst   = rst_i;
    e.busy  = (g >= 0);
    e.wr    = xfer;
    e.grant = m_gid;
    e.ready = (!rst_i && g >= 0 && !full) ? (4'd1 << g) : 4'd0;
    e.cnt   = m_cnt;
    cyc_q.push_back(e);
    if (xfer) wr_q.push_back('{data: pq_data[g][0], id: g});
    if (rst_i) begin
      model_reset();
    end else if (g < 0) begin
      sel = -1;
      for (int k = 1; k <= N; k++) begin
        w = (m_lastw + k) % N;
        if (v[w] && sel < 0) sel = w;
      end
      if (sel >= 0) begin
        m_grantee = sel;
        m_gid     = 2'(sel);
        m_beats   = 0;
      end
    end else if (xfer) begin
      m_cnt = m_cnt + 16'd1;
      m_beats++;
      if (pq_last[g][0] || m_beats == MB) begin
        m_lastw   = g;
        m_grantee = -1;
      end
      void'(pq_data[g].pop_front());
      void'(pq_last[g].pop_front());
    end
  endtask

  task automatic run_random(input int cycles, input int vpct, input int fpct, input int rpct);
    for (int c = 0; c < cycles; c++) begin
      for (int p = 0; p < N; p++)
        if (pq_data[p].size() < 3 && $urandom_range(3) == 0)
          add_burst(p, $urandom_range(1, 6));
      step(vpct, fpct, $urandom_range(99) < rpct);
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (pending() && n < 600) begin
      step(100, 0, 1'b0);
      n++;
    end
    chk(name, 64'(pending()), 64'd0);
  endtask

  // Per-cycle monitor: handshake, grant, status and gating
  always @(negedge clk) begin
    cyc_t e;
    if (cyc_q.size() > 0) begin
      e = cyc_q.pop_front();
      chk("wr_en", 64'(fifo_wr_en), 64'(e.wr));
      chk("req_ready", 64'(req_ready), 64'(e.ready));
      chk("busy", 64'(busy), 64'(e.busy));
      chk("grant_id", 64'(grant_id), 64'(e.grant));
      chk("wr_count", 64'(wr_count), 64'(e.cnt));
      chk("fifo_cs", 64'(fifo_cs), 64'(e.busy && !e.rst));
      if (!e.busy) chk("data_gated", 64'(fifo_data_in), 64'd0);
    end
  end

  // Write monitor: every FIFO write must match the next predicted beat
  always @(negedge clk) begin
    wr_t w;
    if (fifo_wr_en === 1'b1) begin
      if (wr_q.size() == 0) begin
        chk("wr_unexpected", 64'(wr_q.size()), 64'd1);
      end else begin
        w = wr_q.pop_front();
        chk("wr_data", 64'(fifo_data_in), 64'(w.data));
        chk("wr_id", 64'(grant_id), 64'(w.id));
        $display("WR producer=%0d data=%08h count=%0d", grant_id, fifo_data_in, wr_count);
      end
    end
  end

  initial begin
    int n;
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    req_last  = '0;
    fifo_full = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    step(0, 0, 1'b1);
    step(0, 0, 1'b0);

    // Single producer: three beats from producer 2
    add_beat(2, 32'hA0, 1'b0);
    add_beat(2, 32'hA1, 1'b0);
    add_beat(2, 32'hA2, 1'b1);
    drain("single_drain");
    step(100, 0, 1'b0);
    chk("single_count", 64'(wr_count), 64'd3);

    // Round robin with single-beat bursts from everyone
    for (int r = 0; r < 3; r++)
      for (int p = 0; p < N; p++) add_burst(p, 1);
    drain("rr_drain");

    // Burst cap: producer 1 streams ten beats, producer 3 competes
    for (int k = 0; k < 10; k++) add_beat(1, 32'hB100 + 32'(k), k == 9);
    add_burst(3, 3);
    drain("cap_drain");

    // Backpressure and valid gaps under random traffic
    run_random(150, 100, 30, 0);
    drain("bp_drain");
    run_random(200, 60, 10, 0);
    drain("gap_drain");

    // Reset at beat 2 of a 4-beat burst from producer 2, others waiting
    add_burst(2, 4);
    add_burst(3, 2);
    n = 0;
    while (!(m_grantee == 2 && m_beats == 2) && n < 50) begin
      step(100, 0, 1'b0);
      n++;
    end
    chk("reset_reach_beat2", 64'(m_beats), 64'd2);
    step(100, 0, 1'b1);
    step(100, 0, 1'b0);
    drain("post_reset_drain");

    // Mixed random traffic with occasional resets
    run_random(400, 70, 20, 2);
    drain("final_drain");
    step(0, 0, 1'b0);
    step(0, 0, 1'b0);
    @(posedge clk);
    #2;
    chk("wr_queue_empty", 64'(wr_q.size()), 64'd0);
    chk("cyc_queue_empty", 64'(cyc_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
